// File: rtl/raybox_input_conditioner.sv
// raybox_input_conditioner
// Turns the four raw active-low DE0-Nano push-buttons into clean active-high
// raybox controls. The path is a two-flop synchroniser, then a per-button
// debounce, then a settle FSM that waits for the button pattern to stay
// unchanged for a while before decoding it. The settle stage stops a
// two-button debug chord from producing stray move pulses while the buttons
// are still being pressed.
module raybox_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18,
  parameter int SETTLE_CYCLES   = 125000,
  parameter int ST_W            = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] k_n,
  output logic [3:0] k_stable,
  output logic       moveL,
  output logic       moveR,
  output logic       moveF,
  output logic       moveB,
  output logic       debugA,
  output logic       debugB,
  output logic       debugC,
  output logic       debugD
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);
  localparam logic [ST_W-1:0] ST_ZERO = ST_W'(0);

  // Decode a stable button pattern into controls.
  // Result order: {moveL, moveR, moveF, moveB, debugA, debugB, debugC, debugD}.
  // The K2+K3 chord (d1) wins over the K1+K4 chord (d2) when both are held.
  function automatic logic [7:0] decode(input logic [3:0] p);
    logic d1;
    logic d2;
    logic nd;
    d1 = p[1] & p[2];
    d2 = p[0] & p[3] & ~d1;
    nd = ~(p[1] & p[2]) & ~(p[0] & p[3]);
    decode = {nd & p[2], nd & p[1], nd & p[3], nd & p[0],
              d1 & p[3], d1 & p[0], d2 & p[1], d2 & p[2]};
  endfunction

  logic [3:0]      s1_r;
  logic [3:0]      s2_r;
  logic [3:0]      raw_s;
  logic [3:0]      k_stable_r;
  logic [DB_W-1:0] db_cnt_r [4];

  state_t          state_r;
  state_t          state_nx_s;
  logic [3:0]      pat_r;
  logic [3:0]      pat_nx_s;
  logic [ST_W-1:0] sc_r;
  logic [ST_W-1:0] sc_nx_s;
  logic [7:0]      out_r;
  logic [7:0]      out_nx_s;

  // Two-flop synchroniser; flops rest at 1 so every button reads as released.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= 4'hF;
      s2_r <= 4'hF;
    end else begin
      s1_r <= k_n;
      s2_r <= s1_r;
    end
  end

  assign raw_s = ~s2_r;

  // Per-button debounce: a new level must hold DEBOUNCE_CYCLES samples; any bounce restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_stable_r <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= DB_ZERO;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (raw_s[i] == k_stable_r[i]) begin
          db_cnt_r[i] <= DB_ZERO;
        end else if (db_cnt_r[i] == DB_LAST) begin
          k_stable_r[i] <= raw_s[i];
          db_cnt_r[i]   <= DB_ZERO;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
        end
      end
    end
  end

  // Settle FSM state, captured pattern, settle counter and registered controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      pat_r   <= 4'h0;
      sc_r    <= ST_ZERO;
      out_r   <= 8'h00;
    end else begin
      state_r <= state_nx_s;
      pat_r   <= pat_nx_s;
      sc_r    <= sc_nx_s;
      out_r   <= out_nx_s;
    end
  end

  // Next-state logic: any change of the pattern restarts the settle window.
  always_comb begin
    state_nx_s = state_r;
    pat_nx_s   = pat_r;
    sc_nx_s    = sc_r;
    case (state_r)
      ST_IDLE: begin
        if (k_stable_r != 4'h0) begin
          state_nx_s = ST_SETTLE;
          pat_nx_s   = k_stable_r;
          sc_nx_s    = ST_ZERO;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (k_stable_r == 4'h0) begin
          state_nx_s = ST_IDLE;
        end else if (k_stable_r != pat_r) begin
          pat_nx_s = k_stable_r;
          sc_nx_s  = ST_ZERO;
        end else if (sc_r == ST_LAST) begin
          state_nx_s = ST_ACTIVE;
        end else begin
          sc_nx_s = sc_r + ST_ONE;
        end
      end
      ST_ACTIVE: begin
        if (k_stable_r == 4'h0) begin
          state_nx_s = ST_IDLE;
        end else if (k_stable_r != pat_r) begin
          state_nx_s = ST_SETTLE;
          pat_nx_s   = k_stable_r;
          sc_nx_s    = ST_ZERO;
        end else begin
          state_nx_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        pat_nx_s   = 4'h0;
        sc_nx_s    = ST_ZERO;
      end
    endcase
  end

  // Output logic: controls turn on on the edge that enters ACTIVE and drop on the edge that leaves it.
  always_comb begin
    out_nx_s = 8'h00;
    case (state_r)
      ST_IDLE: begin
        out_nx_s = 8'h00;
      end
      ST_SETTLE: begin
        if ((k_stable_r != 4'h0) && (k_stable_r == pat_r) && (sc_r == ST_LAST)) begin
          out_nx_s = decode(k_stable_r);
        end else begin
          out_nx_s = 8'h00;
        end
      end
      ST_ACTIVE: begin
        if ((k_stable_r != 4'h0) && (k_stable_r == pat_r)) begin
          out_nx_s = decode(pat_r);
        end else begin
          out_nx_s = 8'h00;
        end
      end
      default: begin
        out_nx_s = 8'h00;
      end
    endcase
  end

  assign k_stable = k_stable_r;
  assign moveL    = out_r[7];
  assign moveR    = out_r[6];
  assign moveF    = out_r[5];
  assign moveB    = out_r[4];
  assign debugA   = out_r[3];
  assign debugB   = out_r[2];
  assign debugC   = out_r[1];
  assign debugD   = out_r[0];

endmodule
